program_loader: RTL and testbench

- Byte-stream boot loader that fills CPU instruction memory before execution.
- It is the writer counterpart to the end-of-run register readout: the loader puts a program into the CPU, and the bench reads results out.
- Sits between a host byte source (bench driver or UART receiver) and the instruction-memory write port.
- Holds the CPU in reset until a complete, checksum-valid image has been written.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/byte_to_word_packer.sv | 58 +++++
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM states, memory sizing defaults and
// small state-classification helpers used by the program loader.
package cpu_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned LEN_W              = 16;
    localparam int unsigned DEFAULT_IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    // States in which a frame is being received and bytes are accepted.
    function automatic logic is_frame_state(input loader_state_t s);
        return (s inside {LEN0, LEN1, DATA, CSUM});
    endfunction

    // States from which a start pulse arms a new load.
    function automatic logic is_armable(input loader_state_t s);
        return (s inside {IDLE, DONE, ERROR});
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs little-endian stream bytes into 32-bit words and keeps the running
// XOR checksum of every byte it is given.
//   clk, rst      : clock, async active-low reset
//   clear         : synchronous restart of lane index, assembly and checksum
//   byte_valid    : byte_in is consumed this cycle
//   byte_in       : payload byte
//   byte_idx      : lane the next byte lands in (0..3)
//   word_valid    : one-cycle pulse, word_data holds a complete word
//   word_data     : last completed word
//   csum          : XOR of all bytes consumed since clear
module byte_to_word_packer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [1:0]        byte_idx,
    output logic              word_valid,
    output logic [XLEN-1:0]   word_data,
    output logic [BYTE_W-1:0] csum
);

    // Lanes 0..2 are held here; lane 3 goes straight into word_data.
    logic [XLEN-BYTE_W-1:0] asm_q;

    // Byte assembly, word completion pulse and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            csum       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
                asm_q    <= '0;
                csum     <= '0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                csum     <= csum ^ byte_in;
                case (byte_idx)
                    2'd0: asm_q[7:0]   <= byte_in;
                    2'd1: asm_q[15:8]  <= byte_in;
                    2'd2: asm_q[23:16] <= byte_in;
                    default: begin
                        word_data  <= {byte_in, asm_q};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream boot loader: receives a length-prefixed, XOR-checksummed image,
// writes it word by word into instruction memory and keeps the CPU in reset
// until a complete, checksum-valid image has landed.
//   clk, rst       : clock, async active-low reset
//   start          : pulse, arms a new load from IDLE/DONE/ERROR
//   s_data/s_valid : host byte stream, accepted when s_valid && s_ready
//   s_ready        : loader is inside a frame and accepting bytes
//   imem_we/addr/wdata : instruction-memory write port, one strobe per word
//   cpu_rst_hold   : high holds the CPU in reset
//   load_done      : image written and checksum matched
//   load_err       : length overflow or checksum mismatch
//   words_loaded   : words written in the current load
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_rst_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [LEN_W-1:0]  words_loaded
);

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic [BYTE_W-1:0] len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt_q;

    logic              accept_c;
    logic              arm_c;
    logic [LEN_W-1:0]  len_c;
    logic              word_end_c;
    logic              last_word_c;
    logic              s_ready_d;
    logic              load_done_d;
    logic              load_err_d;
    logic              cpu_rst_hold_d;

    logic [1:0]        byte_idx;
    logic [BYTE_W-1:0] csum;

    assign accept_c    = s_valid && s_ready;
    assign arm_c       = start && is_armable(state_q);
    assign len_c       = {s_data, len_lo_q};
    assign word_end_c  = accept_c && (state_q == DATA) && (byte_idx == 2'd3);
    assign last_word_c = ((word_cnt_q + 16'd1) == len_q);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (arm_c),
        .byte_valid (accept_c && (state_q == DATA)),
        .byte_in    (s_data),
        .byte_idx   (byte_idx),
        .word_valid (imem_we),
        .word_data  (imem_wdata),
        .csum       (csum)
    );

    // Next state and next values of the registered status outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) state_d = LEN0;
            end
            LEN0: begin
                if (accept_c) state_d = LEN1;
            end
            LEN1: begin
                if (accept_c) begin
                    if (32'(len_c) > 32'(IMEM_DEPTH)) state_d = ERROR;
                    else if (len_c == '0)             state_d = CSUM;
                    else                              state_d = DATA;
                end
            end
            DATA: begin
                if (word_end_c && last_word_c) state_d = CSUM;
            end
            CSUM: begin
                if (accept_c) state_d = (s_data == csum) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase

        s_ready_d      = is_frame_state(state_d);
        load_done_d    = (state_d == DONE);
        load_err_d     = (state_d == ERROR);
        // Release the CPU only once DONE has been held for a full cycle.
        cpu_rst_hold_d = !((state_q == DONE) && (state_d == DONE));
    end

    // State, length/word bookkeeping, write address and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            s_ready      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            cpu_rst_hold <= 1'b1;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            imem_addr    <= '0;
            words_loaded <= '0;
        end else begin
            state_q      <= state_d;
            s_ready      <= s_ready_d;
            load_done    <= load_done_d;
            load_err     <= load_err_d;
            cpu_rst_hold <= cpu_rst_hold_d;
            if (arm_c) begin
                len_lo_q     <= '0;
                len_q        <= '0;
                word_cnt_q   <= '0;
                imem_addr    <= '0;
                words_loaded <= '0;
            end else begin
                if (accept_c && (state_q == LEN0)) len_lo_q <= s_data;
                if (accept_c && (state_q == LEN1)) len_q <= len_c;
                if (word_end_c) word_cnt_q <= word_cnt_q + 16'd1;
                // Address and count advance after the strobe has been issued.
                if (imem_we) begin
                    imem_addr    <= imem_addr + ADDR_W'(1);
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          start   = 1'b0;
    logic [7:0]    s_data  = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_hold;
    logic          load_done;
    logic          load_err;
    logic [15:0]   words_loaded;

    program_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst_hold (cpu_rst_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;

    // Scoreboard of expected memory writes, filled by the reference model.
    int unsigned exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    logic [7:0]  payload[$];
    logic [7:0]  frame[$];
    logic        exp_done;
    logic        exp_err;
    int unsigned exp_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write strobe pops the next expected write.
    logic        prev_we = 1'b0;
    int unsigned mon_addr;
    logic [31:0] mon_data;
    always @(negedge clk) begin
        if (rst && imem_we) begin
            check("we_not_back_to_back", 32'(prev_we), 32'd0);
            if (exp_addr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with none expected",
                         imem_addr, imem_wdata);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                check("write_addr", 32'(imem_addr), mon_addr);
                check("write_data", imem_wdata, mon_data);
            end
        end
        prev_we = rst && imem_we;
    end

    // Reference model: builds the byte frame and predicts writes and outcome.
    task automatic make_frame(input logic [15:0] len, input bit use_csum, input logic [7:0] csum_val);
        logic [7:0]  x = 8'h00;
        logic [7:0]  c;
        logic [31:0] w;
        frame = {};
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        if (int'(len) > int'(DEPTH)) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_words = 0;
            return;
        end
        for (int i = 0; i < 4 * int'(len); i++) begin
            frame.push_back(payload[i]);
            x = x ^ payload[i];
        end
        for (int k = 0; k < int'(len); k++) begin
            w = 32'(payload[4*k]) + (32'(payload[4*k+1]) << 8)
              + (32'(payload[4*k+2]) << 16) + (32'(payload[4*k+3]) << 24);
            exp_addr_q.push_back(k % DEPTH);
            exp_data_q.push_back(w);
        end
        c = use_csum ? csum_val : x;
        frame.push_back(c);
        exp_done  = (c == x);
        exp_err   = !exp_done;
        exp_words = int'(len);
    endtask

    task automatic nominal_payload();
        payload = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    endtask

    task automatic random_payload(input int n);
        payload = {};
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    endtask

    // Drive one byte from a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit with_start);
        int waited = 0;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        while (!s_ready) begin
            if (waited > 50) begin
                checks++;
                $display("FAIL s_ready_timeout: s_ready stayed 0, byte 0x%02h not accepted", b);
                return;
            end
            waited++;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        if (with_start) start = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int start_at, input int n_bytes);
        for (int i = 0; i < n_bytes; i++) send_byte(frame[i], gap_pct, i == start_at);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_outcome(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_load_done"},    32'(load_done),    32'(exp_done));
        check({tag, "_load_err"},     32'(load_err),     32'(exp_err));
        check({tag, "_words_loaded"}, 32'(words_loaded), exp_words);
        check({tag, "_cpu_rst_hold"}, 32'(cpu_rst_hold), 32'(!exp_done));
        check({tag, "_s_ready"},      32'(s_ready),      32'd0);
        check({tag, "_writes_drained"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ready",      32'(s_ready),      32'd0);
        check("rst_imem_we",      32'(imem_we),      32'd0);
        check("rst_imem_addr",    32'(imem_addr),    32'd0);
        check("rst_imem_wdata",   imem_wdata,        32'd0);
        check("rst_cpu_rst_hold", 32'(cpu_rst_hold), 32'd1);
        check("rst_load_done",    32'(load_done),    32'd0);
        check("rst_load_err",     32'(load_err),     32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal two-word image; checksum is the XOR of the payload.
        nominal_payload();
        make_frame(16'd2, 1'b0, 8'h00);
        pulse_start();
        send_frame(0, -1, frame.size());
        check("nom_done_on_entry", 32'(load_done),    32'd1);
        check("nom_hold_on_entry", 32'(cpu_rst_hold), 32'd1);
        @(negedge clk);
        check("nom_hold_released", 32'(cpu_rst_hold), 32'd0);
        check_outcome("nominal");

        // Reload from DONE: hold reasserts next cycle; a start inside DATA is ignored.
        pulse_start();
        check("reload_hold",      32'(cpu_rst_hold), 32'd1);
        check("reload_done_clr",  32'(load_done),    32'd0);
        check("reload_s_ready",   32'(s_ready),      32'd1);
        nominal_payload();
        make_frame(16'd2, 1'b0, 8'h00);
        send_frame(0, 4, frame.size());
        check_outcome("reload");

        // Bad checksum: both words still written, then ERROR.
        nominal_payload();
        make_frame(16'd2, 1'b1, 8'h17);
        pulse_start();
        send_frame(0, -1, frame.size());
        check_outcome("bad_csum");

        // Oversize length: ERROR right after LEN_HI, no writes.
        make_frame(16'(DEPTH + 1), 1'b0, 8'h00);
        pulse_start();
        send_frame(0, -1, frame.size());
        check_outcome("oversize");

        // Zero-length image.
        payload = {};
        make_frame(16'd0, 1'b1, 8'h00);
        pulse_start();
        send_frame(0, -1, frame.size());
        check_outcome("zero_len");

        // Nominal image with random s_valid gaps.
        nominal_payload();
        make_frame(16'd2, 1'b0, 8'h00);
        pulse_start();
        send_frame(40, -1, frame.size());
        check_outcome("gapped");

        // Reset after five payload bytes: only the first word reaches memory.
        nominal_payload();
        pulse_start();
        frame = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93};
        exp_addr_q.push_back(0);
        exp_data_q.push_back(32'h00A00513);
        send_frame(0, -1, 7);
        rst = 1'b0;
        #1;
        check("midrst_s_ready",      32'(s_ready),      32'd0);
        check("midrst_cpu_rst_hold", 32'(cpu_rst_hold), 32'd1);
        check("midrst_load_done",    32'(load_done),    32'd0);
        check("midrst_words_loaded", 32'(words_loaded), 32'd0);
        check("midrst_writes_drained", 32'(exp_addr_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        make_frame(16'd2, 1'b0, 8'h00);
        pulse_start();
        send_frame(0, -1, frame.size());
        check_outcome("after_rst");

        // Randomized frames, some with corrupted checksums and gaps.
        for (int t = 0; t < 10; t++) begin
            int n;
            n = int'($urandom_range(0, 6));
            random_payload(n);
            if ($urandom_range(3) == 0)
                make_frame(16'(n), 1'b1, 8'($urandom));
            else
                make_frame(16'(n), 1'b0, 8'h00);
            pulse_start();
            send_frame(int'($urandom_range(0, 30)), -1, frame.size());
            check_outcome("random");
        end

        // Image that fills all of memory.
        random_payload(DEPTH);
        make_frame(16'(DEPTH), 1'b0, 8'h00);
        pulse_start();
        send_frame(0, -1, frame.size());
        check_outcome("full_depth");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
